// File: rtl/jesd204_tx_header_gearbox_pkg.sv
// Shared JESD204 TX definitions.
// Sync headers, gearbox period and block types.
package jesd204_tx_header_gearbox_pkg;

  localparam logic [1:0] SH_DATA    = 2'b01;
  localparam logic [1:0] SH_CTRL    = 2'b10;
  localparam logic [1:0] SH_INVALID = 2'b00;

  localparam int GEARBOX_PERIOD = 33;
  localparam int CNT_MAX        = GEARBOX_PERIOD - 1;
  localparam int CNT_W          = 6;

  typedef logic [65:0]      blk_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic hdr_ok(logic [1:0] h);
    return (h == SH_DATA) || (h == SH_CTRL);
  endfunction

endpackage

// File: rtl/jesd204_tx_header_gearbox_if.sv
// 66-bit block handshake between header logic and gearbox.
// The master offers a block; the gearbox takes it when ready.
interface jesd204_tx_header_gearbox_if;
  import jesd204_tx_header_gearbox_pkg::*;

  blk_t blk;
  logic ready;

  modport master (output blk, input ready);
  modport slave  (input blk, output ready);

endinterface

// File: rtl/jesd204_tx_gearbox_66_64.sv
// 66:64 gearbox: appends each block above the residue.
// Every 33rd cycle it stalls input and flushes 64 residual bits.
module jesd204_tx_gearbox_66_64
  import jesd204_tx_header_gearbox_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  jesd204_tx_header_gearbox_if.slave    blk_if,
  output logic [63:0]                   o_data,
  output logic                          o_valid
);

  cnt_t        cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic [63:0] data_q, data_d;
  logic        valid_q;
  logic        wrap;
  logic [127:0] buf_w;

  assign wrap = (cnt_q == cnt_t'(CNT_MAX));
  assign blk_if.ready = ~wrap;

  // residue bits above 2*cnt are always zero, so OR merges cleanly
  assign buf_w = {64'b0, res_q}
               | ({62'b0, blk_if.blk} << {cnt_q, 1'b0});

  always_comb begin
    cnt_d  = cnt_q;
    res_d  = res_q;
    data_d = data_q;
    unique case (1'b1)
      wrap: begin
        data_d = res_q;
        res_d  = '0;
        cnt_d  = '0;
      end
      default: begin
        data_d = buf_w[63:0];
        res_d  = buf_w[127:64];
        cnt_d  = cnt_q + cnt_t'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      res_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      data_q  <= data_d;
      valid_q <= 1'b1;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/jesd204_tx_header_gearbox.sv
// JESD204 TX header stage: error injection, header error
// counter, and the 66:64 gearbox.
module jesd204_tx_header_gearbox
  import jesd204_tx_header_gearbox_pkg::*;
#(
  parameter int unsigned ERR_BLOCKS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_data,
  input  logic [1:0]  i_header,
  output logic        o_ready,
  input  logic        i_err_inject,
  output logic [63:0] o_data,
  output logic        o_valid,
  output logic [7:0]  o_hdr_err_cnt,
  output logic        o_inject_active
);

  jesd204_tx_header_gearbox_if gb_if ();

  logic       act_q, act_d;
  logic [7:0] left_q, left_d;
  logic [7:0] err_q, err_d;
  logic       start;
  logic       use_inj;
  logic [7:0] left_cur;
  logic [7:0] left_dec;
  logic [1:0] hdr_w;

  assign o_ready  = gb_if.ready;
  assign start    = i_err_inject & ~act_q;
  assign use_inj  = act_q | start;
  assign left_cur = start ? 8'(ERR_BLOCKS) : left_q;
  assign left_dec = left_cur - 8'd1;
  assign hdr_w    = (use_inj && o_ready) ? SH_INVALID : i_header;

  assign gb_if.blk = {hdr_w, i_data};

  always_comb begin
    act_d  = act_q;
    left_d = left_q;
    err_d  = err_q;
    if (use_inj) begin
      // the gap cycle holds the remaining count
      if (o_ready) begin
        left_d = left_dec;
        act_d  = (left_dec != 8'd0);
      end else begin
        left_d = left_cur;
        act_d  = 1'b1;
      end
    end
    if (o_ready && !hdr_ok(i_header) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q  <= 1'b0;
      left_q <= '0;
      err_q  <= '0;
    end else begin
      act_q  <= act_d;
      left_q <= left_d;
      err_q  <= err_d;
    end
  end

  jesd204_tx_gearbox_66_64 u_gearbox (
    .clk    (clk),
    .reset  (reset),
    .blk_if (gb_if.slave),
    .o_data (o_data),
    .o_valid(o_valid)
  );

  assign o_hdr_err_cnt   = err_q;
  assign o_inject_active = act_q;

endmodule

// File: tb/tb_jesd204_tx_header_gearbox.sv
// Directed bench for jesd204_tx_header_gearbox.
// Unpacks the output stream and compares against hand-derived blocks.
module tb_jesd204_tx_header_gearbox;
  import jesd204_tx_header_gearbox_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_err_inject;
  logic [63:0] o_data;
  logic        o_valid;
  logic [7:0]  o_hdr_err_cnt;
  logic        o_inject_active;

  jesd204_tx_header_gearbox_if tb_if ();

  jesd204_tx_header_gearbox #(.ERR_BLOCKS(17)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_data         (tb_if.blk[63:0]),
    .i_header       (tb_if.blk[65:64]),
    .o_ready        (tb_if.ready),
    .i_err_inject   (i_err_inject),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_hdr_err_cnt  (o_hdr_err_cnt),
    .o_inject_active(o_inject_active)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  logic [63:0] words  [0:511];
  logic        rdy_tr [0:511];
  logic        act_tr [0:511];
  logic        vld_tr [0:511];
  logic [7:0]  err_tr [0:511];
  int          nacc;

  function automatic logic [65:0] get_blk(int n);
    logic [65:0] b;
    int p;
    for (int i = 0; i < 66; i++) begin
      p = 66 * n + i;
      b[i] = words[p / 64][p % 64];
    end
    return b;
  endfunction

  // blocks offered during reset carry junk that must never appear
  task automatic do_reset();
    reset = 1'b1;
    i_err_inject = 1'b0;
    tb_if.blk = {2'b10, 64'hDEAD_BEEF_CAFE_F00D};
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_stream(int ncyc, int inj1, int inj2,
                            logic [1:0] hdr);
    int blk;
    logic acc;
    blk = 0;
    for (int k = 1; k <= ncyc; k++) begin
      tb_if.blk = {hdr, 64'(blk)};
      i_err_inject = (k == inj1) || (k == inj2);
      rdy_tr[k] = tb_if.ready;
      acc = tb_if.ready;
      @(posedge clk);
      #1;
      if (acc) blk++;
      words[k-1] = o_data;
      act_tr[k] = o_inject_active;
      vld_tr[k] = o_valid;
      err_tr[k] = o_hdr_err_cnt;
    end
    i_err_inject = 1'b0;
    nacc = blk;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_err_inject = 1'b0;
    tb_if.blk = {2'b01, 64'h1234};
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (tb_if.ready !== 1'b1) begin
      nerr++; $display("FAIL rst_ready got %b exp 1", tb_if.ready);
    end
    nchk++;
    if (o_valid !== 1'b0) begin
      nerr++; $display("FAIL rst_valid got %b exp 0", o_valid);
    end
    nchk++;
    if (o_data !== 64'h0) begin
      nerr++; $display("FAIL rst_data got %h exp 0", o_data);
    end
    nchk++;
    if (o_hdr_err_cnt !== 8'h0) begin
      nerr++; $display("FAIL rst_errcnt got %0d exp 0", o_hdr_err_cnt);
    end
    nchk++;
    if (o_inject_active !== 1'b0) begin
      nerr++; $display("FAIL rst_inj got %b exp 0", o_inject_active);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic exp_r;
    logic [65:0] got;
    do_reset();
    run_stream(99, 0, 0, SH_DATA);
    for (int k = 1; k <= 99; k++) begin
      exp_r = (k % 33) != 0;
      nchk++;
      if (rdy_tr[k] !== exp_r) begin
        nerr++;
        $display("FAIL stream_ready cyc %0d got %b exp %b",
                 k, rdy_tr[k], exp_r);
      end
    end
    nchk++;
    if (vld_tr[1] !== 1'b1) begin
      nerr++; $display("FAIL stream_valid got %b exp 1", vld_tr[1]);
    end
    for (int n = 0; n < 96; n++) begin
      got = get_blk(n);
      nchk++;
      if (got !== {2'b01, 64'(n)}) begin
        nerr++;
        $display("FAIL stream_blk %0d got %h exp %h",
                 n, got, {2'b01, 64'(n)});
      end
    end
  endtask

  task automatic test_ones();
    do_reset();
    tb_if.blk = {2'b10, 64'hFFFF_FFFF_FFFF_FFFF};
    @(posedge clk);
    #1;
    nchk++;
    if (o_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      nerr++; $display("FAIL ones_w0 got %h exp all ones", o_data);
    end
    tb_if.blk = {2'b01, 64'h0};
    @(posedge clk);
    #1;
    nchk++;
    if (o_data !== 64'h2) begin
      nerr++; $display("FAIL ones_w1 got %h exp 2", o_data);
    end
  endtask

  task automatic test_inject();
    logic [1:0]  eh;
    logic        ea;
    logic [65:0] got;
    do_reset();
    run_stream(66, 32, 40, SH_DATA);
    for (int n = 0; n < 64; n++) begin
      eh = (n >= 31 && n <= 47) ? 2'b00 : 2'b01;
      got = get_blk(n);
      nchk++;
      if (got !== {eh, 64'(n)}) begin
        nerr++;
        $display("FAIL inj_blk %0d got %h exp %h", n, got, {eh, 64'(n)});
      end
    end
    for (int k = 1; k <= 66; k++) begin
      ea = (k >= 32) && (k <= 48);
      nchk++;
      if (act_tr[k] !== ea) begin
        nerr++;
        $display("FAIL inj_active cyc %0d got %b exp %b", k, act_tr[k], ea);
      end
    end
    nchk++;
    if (o_hdr_err_cnt !== 8'd0) begin
      nerr++; $display("FAIL inj_errcnt got %0d exp 0", o_hdr_err_cnt);
    end
  endtask

  task automatic test_err_sat();
    logic [65:0] got;
    do_reset();
    run_stream(310, 0, 0, 2'b11);
    nchk++;
    if (nacc < 300) begin
      nerr++; $display("FAIL sat_blocks got %0d exp >=300", nacc);
    end
    nchk++;
    if (err_tr[100] !== 8'd97) begin
      nerr++; $display("FAIL sat_cnt100 got %0d exp 97", err_tr[100]);
    end
    nchk++;
    if (err_tr[261] !== 8'd254) begin
      nerr++; $display("FAIL sat_cnt261 got %0d exp 254", err_tr[261]);
    end
    nchk++;
    if (err_tr[262] !== 8'd255) begin
      nerr++; $display("FAIL sat_cnt262 got %0d exp 255", err_tr[262]);
    end
    nchk++;
    if (o_hdr_err_cnt !== 8'd255) begin
      nerr++; $display("FAIL sat_final got %0d exp 255", o_hdr_err_cnt);
    end
    got = get_blk(5);
    nchk++;
    if (got !== {2'b11, 64'd5}) begin
      nerr++; $display("FAIL sat_hdr got %h exp %h", got, {2'b11, 64'd5});
    end
  endtask

  task automatic test_reset_mid();
    logic        exp_r;
    logic [65:0] got;
    do_reset();
    run_stream(17, 10, 0, SH_DATA);
    nchk++;
    if (o_inject_active !== 1'b1) begin
      nerr++; $display("FAIL mid_pre_inj got %b exp 1", o_inject_active);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    nchk++;
    if (o_data !== 64'h0) begin
      nerr++; $display("FAIL mid_data got %h exp 0", o_data);
    end
    nchk++;
    if (o_valid !== 1'b0) begin
      nerr++; $display("FAIL mid_valid got %b exp 0", o_valid);
    end
    nchk++;
    if (o_inject_active !== 1'b0) begin
      nerr++; $display("FAIL mid_inj got %b exp 0", o_inject_active);
    end
    nchk++;
    if (tb_if.ready !== 1'b1) begin
      nerr++; $display("FAIL mid_ready got %b exp 1", tb_if.ready);
    end
    reset = 1'b0;
    run_stream(66, 0, 0, SH_DATA);
    for (int k = 1; k <= 66; k++) begin
      exp_r = (k % 33) != 0;
      nchk++;
      if (rdy_tr[k] !== exp_r || act_tr[k] !== 1'b0) begin
        nerr++;
        $display("FAIL mid_ctl cyc %0d got rdy %b act %b exp rdy %b act 0",
                 k, rdy_tr[k], act_tr[k], exp_r);
      end
    end
    for (int n = 0; n < 64; n++) begin
      got = get_blk(n);
      nchk++;
      if (got !== {2'b01, 64'(n)}) begin
        nerr++;
        $display("FAIL mid_blk %0d got %h exp %h", n, got, {2'b01, 64'(n)});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_err_inject = 1'b0;
    tb_if.blk = '0;
    test_reset();
    test_stream();
    test_ones();
    test_inject();
    test_err_sat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
